mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Control FSM for the multicycle MIPS core. It sequences one shared datapath and one unified
//  instruction/data memory through fetch, decode, execute, memory and writeback steps.
//  Memory steps wait on a ready handshake and are bounded by a watchdog.
//  Sits beside the multicycle datapath in the top level; replaces the single-cycle control decode.
// PARAMETERS
//  TIMEOUT  16  max cycles a memory step waits for mem_ready before aborting (>=1)
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  opcode      in   6  instr[31:26] from instruction register
//  funct       in   6  instr[5:0] from instruction register
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completed the access requested this cycle
//  mem_req     out  1  memory access request (held until ready or abort)
//  memwrite    out  1  memory write strobe (valid only with mem_req)
//  iord        out  1  0: address = PC, 1: address = ALUOut
//  irwrite     out  1  load instruction register
//  regwrite    out  1  register file write enable
//  regdst      out  1  0: rt, 1: rd destination
//  memtoreg    out  1  0: ALUOut, 1: data register to regfile
//  alusrca     out  1  0: PC, 1: register A
//  alusrcb     out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  pcsrc       out  2  00 ALU result, 01 ALUOut, 10 jump target
//  pcen        out  1  PC write enable = pcwrite | (branch & zero)
//  illegal     out  1  1-cycle pulse: unsupported opcode/funct decoded
//  bus_err     out  1  1-cycle pulse: memory step hit TIMEOUT
// BEHAVIOUR
//  - Moore FSM; all outputs decode from the state register, except pcen (combinational with zero).
//  - On reset: state=FETCH, watchdog=0. Outputs are forced to 0 during the rst cycle.
//  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
//      On mem_ready: irwrite=1 and pcwrite=1, then go to DECODE. Otherwise stay, with irwrite=pcen=0.
//  - DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by opcode:
//      lw 100011 / sw 101011 -> MEMADR
//      R-type 000000 -> EXECUTE
//      beq 000100 -> BRANCH
//      addi 001000 -> ADDIEX
//      j 000010 -> JUMP
//      any other opcode -> FETCH, with illegal=1
//  - MEMADR: alusrca=1, alusrcb=10, add. Next: MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: mem_req=1, iord=1. Go to MEMWB on mem_ready.
//  - MEMWB: regwrite=1, regdst=0, memtoreg=1, then FETCH.
//  - MEMWRITE: mem_req=1, memwrite=1, iord=1. Go to FETCH on mem_ready.
//  - EXECUTE: alusrca=1, alusrcb=00. Funct decode:
//      100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
//      other funct -> illegal=1, then FETCH (no writeback)
//  - ALUWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
//  - BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1; pcen=zero. Then FETCH.
//  - ADDIEX: alusrca=1, alusrcb=10, add, then ADDIWB.
//  - ADDIWB: regwrite=1, regdst=0, memtoreg=0, then FETCH.
//  - JUMP: pcsrc=10, pcwrite=1, then FETCH.
//  - Watchdog: counts cycles spent in FETCH, MEMREAD or MEMWRITE without mem_ready.
//      It clears on ready or on any state change.
//      When count reaches TIMEOUT-1 with no ready: bus_err=1 for one cycle, go to FETCH,
//      and suppress irwrite, regwrite and pcen. A FETCH timeout re-fetches the same PC.
//  - mem_ready outside a memory state is ignored.
//      mem_ready on the TIMEOUT cycle counts as success; ready wins over abort.
//  - rst mid-instruction: next state is FETCH, with no write strobes in the rst cycle.
//  - Min CPI (ready same cycle): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
// TESTING
//  - rst=1 for 2 cycles, then mem_ready tied 1, lw opcode -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB;
//    regwrite=1 and memtoreg=1 only in cycle 5.
//  - R-type funct 100010, ready=1 -> alucontrol=110 in EXECUTE; regwrite=1 and regdst=1 in ALUWB.
//  - beq with zero=1 -> pcen=1 and pcsrc=01 in BRANCH; the same with zero=0 -> pcen=0.
//  - sw, mem_ready low for 3 cycles in MEMWRITE -> memwrite held 4 cycles, then FETCH.
//  - TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err pulse on 4th cycle; irwrite never asserted.
//  - opcode 111111 -> illegal pulse in DECODE, next state FETCH; rst asserted in MEMREAD -> FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the multicycle MIPS core: sequences the shared datapath and the unified
// memory through fetch/decode/execute/memory/writeback, with a watchdog on memory steps.
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic       bus_err
);

  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t         state;
  logic [WDW-1:0] wd;
  logic           mem_state;
  logic           timeout;
  logic           opcode_ok;
  logic           funct_ok;
  logic [2:0]     alu_funct;
  logic           pcwrite;
  logic           branch;

  // Watchdog expires only when no ready arrives on the last allowed cycle; ready wins.
  assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timeout   = mem_state && !mem_ready && (wd == WD_LAST);

  always_comb begin
    opcode_ok = 1'b1;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: opcode_ok = 1'b1;
      default:                                       opcode_ok = 1'b0;
    endcase
  end

  always_comb begin
    funct_ok  = 1'b1;
    alu_funct = ALU_ADD;
    case (funct)
      6'b100000: alu_funct = ALU_ADD;
      6'b100010: alu_funct = ALU_SUB;
      6'b100100: alu_funct = ALU_AND;
      6'b100101: alu_funct = ALU_OR;
      6'b101010: alu_funct = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // State sequencing and watchdog; the watchdog clears on every state change or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      wd    <= '0;
    end else begin
      wd <= '0;
      case (state)
        FETCH: begin
          if (mem_ready)           state <= DECODE;
          else if (wd != WD_LAST)  wd    <= wd + WDW'(1);
        end
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: begin
          if (opcode == OP_SW)      state <= MEMWRITE;
          else if (opcode == OP_LW) state <= MEMREAD;
          else                      state <= FETCH;
        end
        MEMREAD: begin
          if (mem_ready)           state <= MEMWB;
          else if (wd == WD_LAST)  state <= FETCH;
          else                     wd    <= wd + WDW'(1);
        end
        MEMWRITE: begin
          if (mem_ready || (wd == WD_LAST)) state <= FETCH;
          else                              wd    <= wd + WDW'(1);
        end
        EXECUTE: state <= funct_ok ? ALUWB : FETCH;
        ADDIEX:  state <= ADDIWB;
        default: state <= FETCH;
      endcase
    end
  end

  // Moore decode of the current state; everything is held low while rst is asserted.
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    pcsrc      = 2'b00;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          irwrite    = mem_ready;
          pcwrite    = mem_ready;
          bus_err    = timeout;
        end
        DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
          illegal    = !opcode_ok;
        end
        MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          bus_err = timeout;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWRITE: begin
          mem_req  = 1'b1;
          memwrite = 1'b1;
          iord     = 1'b1;
          bus_err  = timeout;
        end
        EXECUTE: begin
          alusrca    = 1'b1;
          alucontrol = alu_funct;
          illegal    = !funct_ok;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          branch     = 1'b1;
        end
        ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        ADDIWB: regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver queues the expected outputs of each
// cycle, and a monitor compares them on the falling edge.
module tb_mips_multicycle_ctrl;

  localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4,
                 S_MEMWB = 5, S_MEMWRITE = 6, S_EXECUTE = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_ADDIEX = 10, S_ADDIWB = 11, S_JUMP = 12;

  localparam int B_MREQ = 17, B_MWR = 16, B_IORD = 15, B_IRW = 14, B_RW = 13, B_RDST = 12,
                 B_M2R = 11, B_ASA = 10, B_ASB = 8, B_ALU = 5, B_PCS = 3, B_PCEN = 2,
                 B_ILL = 1, B_BERR = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110;

  typedef struct {
    logic [17:0] m;
    logic [17:0] v;
    int          st;
    int          n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, illegal, bus_err;
  logic [17:0] act;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_cyc = 0;
  logic fin = 1'b0;

  logic [5:0] fn_tab[5]  = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab[5] = '{3'b110, 3'b010, 3'b000, 3'b001, 3'b111};

  mips_multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
    .pcen(pcen), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, alucontrol, pcsrc, pcen, illegal, bus_err};

  // Expected outputs per state; fields the state leaves unspecified are masked out.
  function automatic exp_t expv(int st, logic rdy, logic z, logic to, logic ill, logic [2:0] alu);
    exp_t e;
    e.v = '0;
    e.m = '0;
    e.st = st;
    e.n = 0;
    e.m[B_MREQ] = 1'b1; e.m[B_MWR] = 1'b1; e.m[B_IRW] = 1'b1; e.m[B_RW] = 1'b1;
    e.m[B_PCEN] = 1'b1; e.m[B_ILL] = 1'b1; e.m[B_BERR] = 1'b1;
    case (st)
      S_RST: e.m = '1;
      S_FETCH: begin
        e.v[B_MREQ] = 1'b1; e.v[B_IRW] = rdy; e.v[B_PCEN] = rdy; e.v[B_BERR] = to;
        e.v[B_ASB +: 2] = 2'b01; e.v[B_ALU +: 3] = ADD;
        e.m[B_IORD] = 1'b1; e.m[B_ASA] = 1'b1; e.m[B_ASB +: 2] = '1;
        e.m[B_ALU +: 3] = '1; e.m[B_PCS +: 2] = '1;
      end
      S_DECODE: begin
        e.v[B_ASB +: 2] = 2'b11; e.v[B_ALU +: 3] = ADD; e.v[B_ILL] = ill;
        e.m[B_ASA] = 1'b1; e.m[B_ASB +: 2] = '1; e.m[B_ALU +: 3] = '1;
      end
      S_MEMADR, S_ADDIEX: begin
        e.v[B_ASA] = 1'b1; e.v[B_ASB +: 2] = 2'b10; e.v[B_ALU +: 3] = ADD;
        e.m[B_ASA] = 1'b1; e.m[B_ASB +: 2] = '1; e.m[B_ALU +: 3] = '1;
      end
      S_MEMREAD: begin
        e.v[B_MREQ] = 1'b1; e.v[B_IORD] = 1'b1; e.v[B_BERR] = to; e.m[B_IORD] = 1'b1;
      end
      S_MEMWRITE: begin
        e.v[B_MREQ] = 1'b1; e.v[B_MWR] = 1'b1; e.v[B_IORD] = 1'b1; e.v[B_BERR] = to;
        e.m[B_IORD] = 1'b1;
      end
      S_MEMWB: begin
        e.v[B_RW] = 1'b1; e.v[B_M2R] = 1'b1; e.m[B_RDST] = 1'b1; e.m[B_M2R] = 1'b1;
      end
      S_EXECUTE: begin
        e.v[B_ASA] = 1'b1; e.v[B_ILL] = ill; e.v[B_ALU +: 3] = alu;
        e.m[B_ASA] = 1'b1; e.m[B_ASB +: 2] = '1;
        if (!ill) e.m[B_ALU +: 3] = '1;
      end
      S_ALUWB: begin
        e.v[B_RW] = 1'b1; e.v[B_RDST] = 1'b1; e.m[B_RDST] = 1'b1; e.m[B_M2R] = 1'b1;
      end
      S_ADDIWB: begin
        e.v[B_RW] = 1'b1; e.m[B_RDST] = 1'b1; e.m[B_M2R] = 1'b1;
      end
      S_BRANCH: begin
        e.v[B_ASA] = 1'b1; e.v[B_ALU +: 3] = SUB; e.v[B_PCS +: 2] = 2'b01; e.v[B_PCEN] = z;
        e.m[B_ASA] = 1'b1; e.m[B_ASB +: 2] = '1; e.m[B_ALU +: 3] = '1; e.m[B_PCS +: 2] = '1;
      end
      S_JUMP: begin
        e.v[B_PCS +: 2] = 2'b10; e.v[B_PCEN] = 1'b1; e.m[B_PCS +: 2] = '1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input int st, input logic rdy, input logic z, input logic to,
                      input logic ill, input logic [2:0] alu);
    exp_t e;
    rst       = (st == S_RST);
    mem_ready = rdy;
    zero      = z;
    e   = expv(st, rdy, z, to, ill, alu);
    e.n = n_cyc;
    sb.push_back(e);
    n_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int st, input logic rdy);
    step(st, rdy, 1'b0, 1'b0, 1'b0, ADD);
  endtask

  task automatic go_n(input int st, input logic rdy, input int n);
    for (int i = 0; i < n; i++) go(st, rdy);
  endtask

  task automatic front(input logic [5:0] op);
    opcode = op;
    go(S_FETCH, 1'b1);
    go(S_DECODE, 1'b1);
  endtask

  // Monitor: pops and compares one expectation per cycle, then reports.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fin) begin
        n_checks++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ((act & e.m) !== (e.v & e.m)) begin
          n_fail++;
          $display("FAIL cycle%0d state%0d: outputs %b, required %b (mask %b)",
                   e.n, e.st, act & e.m, e.v & e.m, e.m);
        end
      end
    end
  end

  initial begin
    opcode = OP_LW;
    @(posedge clk);
    #1;
    go_n(S_RST, 1'b1, 2);

    // lw with immediate ready: 5 cycles, writeback only in the last
    front(OP_LW);
    go(S_MEMADR, 1'b1); go(S_MEMREAD, 1'b1); go(S_MEMWB, 1'b1);

    // R-type, every supported funct
    for (int i = 0; i < 5; i++) begin
      funct = fn_tab[i];
      front(OP_RTYPE);
      step(S_EXECUTE, 1'b1, 1'b0, 1'b0, 1'b0, alu_tab[i]);
      go(S_ALUWB, 1'b1);
    end

    // unsupported funct: illegal, no writeback
    funct = 6'b000111;
    front(OP_RTYPE);
    step(S_EXECUTE, 1'b1, 1'b0, 1'b0, 1'b1, ADD);

    // beq taken then not taken
    front(OP_BEQ);
    step(S_BRANCH, 1'b1, 1'b1, 1'b0, 1'b0, SUB);
    front(OP_BEQ);
    step(S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, SUB);

    // sw with 3 wait cycles: memwrite held 4 cycles
    front(OP_SW);
    go(S_MEMADR, 1'b1);
    go_n(S_MEMWRITE, 1'b0, 3);
    go(S_MEMWRITE, 1'b1);

    front(OP_ADDI);
    go(S_ADDIEX, 1'b1); go(S_ADDIWB, 1'b1);
    front(OP_J);
    go(S_JUMP, 1'b1);

    // unsupported opcode
    opcode = 6'b111111;
    go(S_FETCH, 1'b1);
    step(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b1, ADD);

    // fetch timeout on 4th cycle, refetch, then ready on the last allowed cycle
    opcode = OP_J;
    go_n(S_FETCH, 1'b0, 3);
    step(S_FETCH, 1'b0, 1'b0, 1'b1, 1'b0, ADD);
    go_n(S_FETCH, 1'b0, 3);
    go(S_FETCH, 1'b1);
    go(S_DECODE, 1'b1); go(S_JUMP, 1'b1);

    // lw: ready on the timeout cycle wins
    front(OP_LW);
    go(S_MEMADR, 1'b1);
    go_n(S_MEMREAD, 1'b0, 3);
    go(S_MEMREAD, 1'b1); go(S_MEMWB, 1'b1);

    // lw read timeout: abort to fetch, no writeback
    front(OP_LW);
    go(S_MEMADR, 1'b1);
    go_n(S_MEMREAD, 1'b0, 3);
    step(S_MEMREAD, 1'b0, 1'b0, 1'b1, 1'b0, ADD);

    // sw write timeout
    front(OP_SW);
    go(S_MEMADR, 1'b1);
    go_n(S_MEMWRITE, 1'b0, 3);
    step(S_MEMWRITE, 1'b0, 1'b0, 1'b1, 1'b0, ADD);

    // reset in MEMREAD: back to fetch with a cleared watchdog
    front(OP_LW);
    go(S_MEMADR, 1'b1);
    go(S_MEMREAD, 1'b0);
    go(S_RST, 1'b1);
    go_n(S_FETCH, 1'b0, 3);
    go(S_FETCH, 1'b1);
    go(S_DECODE, 1'b1); go(S_MEMADR, 1'b1); go(S_MEMREAD, 1'b1); go(S_MEMWB, 1'b1);

    fin = 1'b1;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
